// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams 32-bit words into byte-addressed instruction memory, big-endian
module instr_mem_loader #(
   parameter int          MEM_BYTES = 28,
   parameter logic [31:0] BASE_ADDR = 32'd0,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] load_count,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [7:0]       mem_wdata,
   output logic             busy,
   output logic             done,
   output logic             error
);
   typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
   localparam logic [31:0] LIMIT = BASE_ADDR + 32'(MEM_BYTES);
   state_t           state, state_nxt;
   logic [31:0]      ptr, word, ptr4;
   logic [CNT_W-1:0] remaining;
   logic [1:0]       byte_idx;
   logic             ovf, last_byte;
   assign ptr4      = ptr + 32'd4;
   assign ovf       = ptr4 > LIMIT;
   assign last_byte = byte_idx == 2'd3;
   assign busy      = state != IDLE;
   assign mem_addr  = mem_we ? ptr + 32'(byte_idx) : '0;
   assign mem_wdata = mem_we ? word[{~byte_idx, 3'b000} +: 8] : '0;
   // state register
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   // next state and handshake/write strobes
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:   if (start) state_nxt = (load_count == '0) ? DONE : ACCEPT;
         ACCEPT: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ovf ? DONE : WRITE;
         end
         WRITE:  begin
            mem_we = 1'b1;
            if (last_byte) state_nxt = (remaining == CNT_W'(1)) ? DONE : ACCEPT;
         end
         DONE:   begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   // session datapath: pointer, word count, captured word, byte lane, overflow flag
   always_ff @(posedge clk)
      if (rst) begin
         ptr       <= BASE_ADDR;
         remaining <= '0;
         byte_idx  <= '0;
         word      <= '0;
         error     <= 1'b0;
      end else
         case (state)
            IDLE:   if (start) begin
               remaining <= load_count;
               ptr       <= BASE_ADDR;
               error     <= 1'b0;
            end
            ACCEPT: if (in_valid) begin
               if (ovf) error <= 1'b1;
               else begin
                  word     <= in_data;
                  byte_idx <= '0;
               end
            end
            WRITE:  begin
               byte_idx <= byte_idx + 2'd1;
               if (last_byte) begin
                  ptr       <= ptr4;
                  remaining <= remaining - CNT_W'(1);
               end
            end
            default: ;
         endcase
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed checks of the instruction memory loader
module tb_instr_mem_loader;
   logic        clk, rst, start, in_valid;
   logic [15:0] load_count;
   logic [31:0] in_data;
   logic        in_ready, mem_we, busy, done, error;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   int total = 0, bad = 0;
   int cyc = 0, wr_cnt = 0, rdy_cnt = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0, rdy_wr = 0;
   int t0, w0, d0, b0, r0;
   logic [7:0]  mem   [0:255];
   logic [31:0] log_a [0:511];
   logic [7:0]  log_d [0:511];
   logic [31:0] exp_w [0:7];

   instr_mem_loader #(.MEM_BYTES(28), .BASE_ADDR(32'd0), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .load_count(load_count),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .error(error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // memory model and activity log, sampled mid-cycle
   always @(negedge clk) begin
      cyc++;
      if (mem_we) begin
         mem[mem_addr[7:0]] = mem_wdata;
         log_a[wr_cnt] = mem_addr;
         log_d[wr_cnt] = mem_wdata;
         wr_cnt++;
      end
      if (in_ready) rdy_cnt++;
      if (in_ready && mem_we) rdy_wr++;
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int cnt);
      start = 1'b1;
      load_count = 16'(cnt);
      step();
      start = 1'b0;
      t0 = cyc;
      w0 = wr_cnt;
      d0 = done_cnt;
      b0 = busy_cnt;
      r0 = rdy_cnt;
   endtask

   task automatic send(input logic [31:0] w, input bit hold);
      logic hs;
      hs = 1'b0;
      in_data = w;
      in_valid = 1'b1;
      for (int i = 0; i < 40 && !hs; i++) begin
         hs = in_ready;
         step();
      end
      chk("handshake", 32'(hs), 32'd1);
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && done_cnt == d0; i++) step();
      chk("done_seen", 32'(done_cnt - d0), 32'd1);
   endtask

   task automatic chk_log(input int n);
      logic [31:0] w;
      for (int k = 0; k < n; k++) begin
         w = exp_w[k / 4];
         chk($sformatf("addr%0d", k), log_a[w0 + k], 32'(k));
         chk($sformatf("byte%0d", k), 32'(log_d[w0 + k]), 32'(w[8 * (3 - k % 4) +: 8]));
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_out"}, {26'd0, in_ready, mem_we, busy, done, error, 1'b0}, 32'd0);
      chk({tag, "_addr"}, mem_addr, 32'd0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      load_count = '0;
      in_valid = 1'b0;
      in_data = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
      exp_w[0] = 32'h00220000; exp_w[1] = 32'h00430820; exp_w[2] = 32'h00A41022;
      exp_w[3] = 32'h00C51824; exp_w[4] = 32'h01062025; exp_w[5] = 32'h0127282A;
      exp_w[6] = 32'h01483026; exp_w[7] = 32'hDEADBEEF;
      repeat (3) step();
      chk_idle_zero("reset");
      rst = 1'b0;
      step();

      // seven-word program with valid held high
      do_start(7);
      for (int w = 0; w < 7; w++) send(exp_w[w], 1'b1);
      in_valid = 1'b0;
      wait_done();
      chk("prog_done_cyc", 32'(done_cyc - t0), 32'd36);
      chk("prog_writes", 32'(wr_cnt - w0), 32'd28);
      chk("prog_error", 32'(error), 32'd0);
      chk("prog_rdy_wr", 32'(rdy_wr), 32'd0);
      chk_log(28);
      for (int w = 0; w < 7; w++)
         chk($sformatf("fetch%0d", w), {mem[4*w], mem[4*w+1], mem[4*w+2], mem[4*w+3]}, exp_w[w]);

      // eighth word overflows a 28-byte memory
      do_start(8);
      for (int w = 0; w < 8; w++) send(exp_w[w], 1'b1);
      in_valid = 1'b0;
      wait_done();
      chk("ovf_writes", 32'(wr_cnt - w0), 32'd28);
      chk("ovf_error", 32'(error), 32'd1);
      chk_log(28);
      repeat (3) step();
      chk("ovf_error_hold", 32'(error), 32'd1);
      chk("ovf_idle", 32'(busy), 32'd0);

      // zero-length session; start also clears the sticky error
      do_start(0);
      chk("zero_error_clr", 32'(error), 32'd0);
      chk("zero_busy", 32'(busy), 32'd1);
      chk("zero_done_now", 32'(done), 32'd1);
      wait_done();
      repeat (2) step();
      chk("zero_done_cyc", 32'(done_cyc - t0), 32'd1);
      chk("zero_busy_cyc", 32'(busy_cnt - b0), 32'd1);
      chk("zero_writes", 32'(wr_cnt - w0), 32'd0);
      chk("zero_ready", 32'(rdy_cnt - r0), 32'd0);

      // backpressure: gaps of idle valid while accepting
      exp_w[0] = 32'h12345678; exp_w[1] = 32'h9ABCDEF0;
      do_start(2);
      repeat (3) step();
      send(exp_w[0], 1'b0);
      repeat (7) step();
      send(exp_w[1], 1'b0);
      wait_done();
      chk("bp_writes", 32'(wr_cnt - w0), 32'd8);
      chk("bp_rdy_wr", 32'(rdy_wr), 32'd0);
      chk_log(8);

      // reset while the third byte is being written
      exp_w[0] = 32'hCAFEF00D;
      do_start(1);
      send(exp_w[0], 1'b0);
      step();
      step();
      chk("rst_b2_addr", mem_addr, 32'd2);
      chk("rst_b2_data", 32'(mem_wdata), 32'h000000F0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle_zero("midrst");
      chk("rst_partial", 32'(wr_cnt - w0), 32'd3);
      exp_w[0] = 32'h0BADC0DE;
      do_start(1);
      send(exp_w[0], 1'b0);
      wait_done();
      chk("rst_new_writes", 32'(wr_cnt - w0), 32'd4);
      chk_log(4);

      // start during WRITE is ignored
      exp_w[0] = 32'h87654321;
      do_start(1);
      send(exp_w[0], 1'b0);
      start = 1'b1;
      load_count = 16'd5;
      step();
      start = 1'b0;
      wait_done();
      repeat (3) step();
      chk("ign_writes", 32'(wr_cnt - w0), 32'd4);
      chk("ign_busy_cyc", 32'(busy_cnt - b0), 32'd6);
      chk("ign_idle", 32'(busy), 32'd0);
      chk_log(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
